sd_block_dev: RTL and testbench
===============================

Name: sd_block_dev

Overview:
- Parametrised MMIO SD-card block device: CPU-visible register file plus an internal one-sector buffer.
- A command FSM moves whole sectors between that buffer and a word-wide backing-store port using a req/ack handshake.
- Sits on the device bus alongside the other MMIO devices; the backing store is an SDRAM/DPI model or a real SD PHY shim.

Parameters:
- DATA_W, 64, MMIO and backing-port data width in bits (power of 2, ≥32).
- ADDR_W, 7, MMIO word-address width.
- BLK_BYTES, 512, sector size in bytes; buffer depth DEPTH = BLK_BYTES*8/DATA_W words.
- SECTOR_W, 32, sector-number width.
- CAPACITY, 2**20, number of valid sectors.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cen  in  1  MMIO read enable
- wen  in  1  MMIO write enable
- addr  in  ADDR_W  MMIO word address
- wdata  in  DATA_W  MMIO write data
- rdata  out  DATA_W  MMIO read data, registered
- blk_req  out  1  backing-store request, held until ack
- blk_we  out  1  1 = write word, 0 = read word
- blk_addr  out  SECTOR_W+log2(DEPTH)  {sector, word index}
- blk_wdata  out  DATA_W  write word
- blk_ack  in  1  request accepted; rdata valid this cycle when blk_we=0
- blk_rdata  in  DATA_W  read word

Behaviour:
- Registers (word index):
  - 0 CMD: W; 1 = READ sector into buffer, 2 = WRITE buffer to sector, other values ignored.
  - 1 SECTOR: R/W.
  - 2 STATUS: R; bit0 busy, bit1 done, bit2 err. Bits 1–2 are write-1-to-clear.
  - 3 BUFPTR: R/W, log2(DEPTH) bits.
  - 4 BUFDATA: R/W; each access auto-increments BUFPTR.
  - 5 CAP: RO = CAPACITY.
  - 6 IE: only with the optional feature.
  - Unmapped indices read 0; writes to them are dropped.
- MMIO reads: rdata updates on the clock edge after cen=1 (1-cycle latency) and holds otherwise.
- cen and wen together on the same register: rdata returns the pre-write value; the write still takes effect. For BUFDATA, BUFPTR increments once.
- Reset (reset=0 at an edge): rdata=0, blk_req=0, blk_we=0, blk_addr=0, blk_wdata=0; all registers 0; FSM to IDLE. Applies mid-transfer: blk_req is 0 after that edge; buffer contents are undefined.
- FSM states:
  - IDLE → XFER on a valid CMD when not busy and SECTOR < CAPACITY. On entry: busy=1, done=0, word counter=0, blk_req=1 next cycle.
  - XFER: blk_req stays high. On blk_ack, the word is committed:
    - READ: buf[cnt] ← blk_rdata.
    - WRITE: blk_wdata = buf[cnt].
    - Then cnt++ and blk_addr follows cnt.
  - On ack of word DEPTH-1: blk_req=0, busy=0, done=1, back to IDLE. The new state is visible in STATUS the cycle after the last ack.
  - One word per ack; back-to-back acks are legal; a request lasts ≥1 cycle.
- Error and guard conditions:
  - CMD while busy: ignored, err=1, current transfer unaffected.
  - CMD with SECTOR ≥ CAPACITY: no transfer, err=1, done stays 0.
  - SECTOR write while busy: ignored. The latched sector is used for the whole transfer.
  - BUFDATA/BUFPTR access while busy: reads return 0, writes dropped, no increment.
- BUFPTR wraps from DEPTH-1 to 0.
- Buffer is a single-port array; FSM and CPU accesses are mutually exclusive because of the busy guard.

Optional Feature:
- SD_BLOCK_DEV_IRQ_EN defined:
  - Adds output port irq (1 bit) and register 6 IE (bit0 done-enable, bit1 err-enable, R/W).
  - irq = (done & IE[0]) | (err & IE[1]), registered, reset 0.
- Undefined: no irq port; register 6 reads 0 and writes are dropped.

Decomposition:
- Package sd_block_pkg:
  - Register index localparams.
  - CMD codes.
  - STATUS bit positions.
  - FSM state enum {IDLE, XFER}.
- One sub-module, sd_block_buf: parametrised DEPTH×DATA_W single-port RAM (synchronous write, registered read), so it can be swapped for a memory macro.

Test Plan:
- Buffer fill: reset, write BUFPTR=0, write BUFDATA 0x1111_0000+i for i=0..63, write BUFPTR=0, read BUFDATA ×64 → same values in order; BUFPTR reads 0 after 64 accesses (wrap).
- Read transfer: SECTOR=5, CMD=1, ack every cycle with blk_rdata=0xA5A5_0000+idx.
  - blk_addr runs {5,0}..{5,63}.
  - busy=1 throughout; STATUS=0b010 the cycle after the 64th ack.
  - Buffer readback matches.
- Write transfer with stalls: CMD=2, ack every third cycle → blk_we=1, blk_wdata=buf[i] held stable until each ack, exactly 64 acked words.
- Range error: SECTOR=CAPACITY, CMD=1 → no blk_req, STATUS=0b100. Write STATUS=0b100 → STATUS=0.
- Busy guard: during READ, issue CMD=2, write SECTOR=9, read BUFDATA.
  - err set; rdata=0; blk_addr sector stays 5; transfer completes normally.
- Reset mid-transfer: drive reset=0 at word 20 → blk_req=0 next cycle, STATUS=0, rdata=0. IRQ build: irq=0.

Source files
------------

// File: rtl/sd_block_pkg.sv
// rtl/sd_block_pkg.sv - register map, command codes, status bits and FSM states for sd_block_dev
package sd_block_pkg;

    // MMIO word indices
    localparam int REG_CMD     = 0;
    localparam int REG_SECTOR  = 1;
    localparam int REG_STATUS  = 2;
    localparam int REG_BUFPTR  = 3;
    localparam int REG_BUFDATA = 4;
    localparam int REG_CAP     = 5;
    localparam int REG_IE      = 6;

    // CMD register codes
    localparam int CMD_READ  = 1;
    localparam int CMD_WRITE = 2;

    // STATUS bit positions
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

endpackage

// File: rtl/sd_block_buf.sv
// rtl/sd_block_buf.sv - one-sector single-port RAM, synchronous write, registered read-first output
module sd_block_buf #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [PTR_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Output register only moves on a read so callers can rely on it holding
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // No reset on the array or its output: contents are undefined after reset, like a macro
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sd_block_dev.sv
// rtl/sd_block_dev.sv - MMIO SD block device with sector buffer and req/ack backing port; SD_BLOCK_DEV_IRQ_EN adds irq and IE
module sd_block_dev
    import sd_block_pkg::*;
#(
    parameter int          DATA_W    = 64,
    parameter int          ADDR_W    = 7,
    parameter int          BLK_BYTES = 512,
    parameter int          SECTOR_W  = 32,
    parameter int unsigned CAPACITY  = 32'd1 << 20,
    localparam int         DEPTH     = BLK_BYTES * 8 / DATA_W,
    localparam int         PTR_W     = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cen,
    input  logic                      wen,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      blk_req,
    output logic                      blk_we,
    output logic [SECTOR_W+PTR_W-1:0] blk_addr,
    output logic [DATA_W-1:0]         blk_wdata,
    input  logic                      blk_ack,
    input  logic [DATA_W-1:0]         blk_rdata
`ifdef SD_BLOCK_DEV_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam logic [SECTOR_W:0] CAP_EXT = (SECTOR_W + 1)'(CAPACITY);

    state_e              state_q, state_d;
    logic [SECTOR_W-1:0] sector_q, sector_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [PTR_W-1:0]    bufptr_q, bufptr_d;
    logic [PTR_W-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic                blk_req_q, blk_req_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                buf_sel_q, buf_sel_d;
`ifdef SD_BLOCK_DEV_IRQ_EN
    logic [1:0]          ie_q, ie_d;
    logic                irq_q, irq_d;
`endif

    logic                busy;
    logic                hit_cmd, hit_sector, hit_status, hit_bufptr, hit_bufdata, hit_cap, hit_ie;
    logic                cmd_valid, cmd_is_write, in_range;
    logic [2:0]          status;
    logic [DATA_W-1:0]   rd_val;
    logic                ram_we, ram_re;
    logic [PTR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    assign busy = (state_q == XFER);

    // Address decode, command qualification and the CPU read mux
    always_comb begin
        hit_cmd      = (addr == ADDR_W'(REG_CMD));
        hit_sector   = (addr == ADDR_W'(REG_SECTOR));
        hit_status   = (addr == ADDR_W'(REG_STATUS));
        hit_bufptr   = (addr == ADDR_W'(REG_BUFPTR));
        hit_bufdata  = (addr == ADDR_W'(REG_BUFDATA));
        hit_cap      = (addr == ADDR_W'(REG_CAP));
        hit_ie       = (addr == ADDR_W'(REG_IE));
        cmd_is_write = (wdata == DATA_W'(CMD_WRITE));
        cmd_valid    = wen && hit_cmd && ((wdata == DATA_W'(CMD_READ)) || cmd_is_write);
        in_range     = ({1'b0, sector_q} < CAP_EXT);

        status          = 3'b000;
        status[ST_BUSY] = busy;
        status[ST_DONE] = done_q;
        status[ST_ERR]  = err_q;

        // BUFDATA reads return 0 here; the RAM output is steered onto rdata a cycle later
        rd_val = '0;
        if (hit_sector) rd_val = DATA_W'(sector_q);
        if (hit_status) rd_val = DATA_W'(status);
        if (hit_bufptr && !busy) rd_val = DATA_W'(bufptr_q);
        if (hit_cap) rd_val = DATA_W'(CAPACITY);
`ifdef SD_BLOCK_DEV_IRQ_EN
        if (hit_ie) rd_val = DATA_W'(ie_q);
`endif
    end

    // Next-state for registers, transfer FSM and RAM port arbitration
    always_comb begin
        state_d   = state_q;
        sector_d  = sector_q;
        done_d    = done_q;
        err_d     = err_q;
        bufptr_d  = bufptr_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        blk_req_d = blk_req_q;
        rdata_d   = rdata_q;
        buf_sel_d = buf_sel_q;
`ifdef SD_BLOCK_DEV_IRQ_EN
        ie_d      = ie_q;
`endif

        if (cen) begin
            rdata_d   = rd_val;
            buf_sel_d = hit_bufdata && !busy;
        end else if (buf_sel_q) begin
            // Freeze the RAM word so later FSM reads cannot disturb rdata
            rdata_d   = ram_rdata;
            buf_sel_d = 1'b0;
        end

        if (wen && hit_sector && !busy) sector_d = wdata[SECTOR_W-1:0];
        if (wen && hit_status) begin
            if (wdata[ST_DONE]) done_d = 1'b0;
            if (wdata[ST_ERR])  err_d  = 1'b0;
        end
        if (wen && hit_bufptr && !busy) bufptr_d = wdata[PTR_W-1:0];
        if ((cen || wen) && hit_bufdata && !busy) bufptr_d = bufptr_q + 1'b1;
`ifdef SD_BLOCK_DEV_IRQ_EN
        if (wen && hit_ie) ie_d = wdata[1:0];
`endif

        if (cmd_valid) begin
            if (busy || !in_range) begin
                err_d = 1'b1;
            end else begin
                state_d   = XFER;
                done_d    = 1'b0;
                cnt_d     = '0;
                dir_d     = cmd_is_write;
                blk_req_d = 1'b1;
            end
        end

        if (busy && blk_ack) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PTR_W'(DEPTH - 1)) begin
                state_d   = IDLE;
                blk_req_d = 1'b0;
                dir_d     = 1'b0;
                done_d    = 1'b1;
            end
        end

        // FSM owns the RAM while busy; for writes it prefetches the word blk_wdata must show next cycle
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = bufptr_q;
        ram_wdata = wdata;
        if (busy && !dir_q) begin
            ram_we    = blk_ack;
            ram_addr  = cnt_q;
            ram_wdata = blk_rdata;
        end else if (state_d == XFER && dir_d) begin
            ram_re   = 1'b1;
            ram_addr = cnt_d;
        end else if (!busy && hit_bufdata) begin
            ram_we = wen;
            ram_re = cen;
        end

`ifdef SD_BLOCK_DEV_IRQ_EN
        irq_d = (done_d & ie_d[0]) | (err_d & ie_d[1]);
`endif
    end

    // All device state, with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            sector_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bufptr_q  <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            blk_req_q <= 1'b0;
            rdata_q   <= '0;
            buf_sel_q <= 1'b0;
`ifdef SD_BLOCK_DEV_IRQ_EN
            ie_q      <= 2'b00;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sector_q  <= sector_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bufptr_q  <= bufptr_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            blk_req_q <= blk_req_d;
            rdata_q   <= rdata_d;
            buf_sel_q <= buf_sel_d;
`ifdef SD_BLOCK_DEV_IRQ_EN
            ie_q      <= ie_d;
            irq_q     <= irq_d;
`endif
        end
    end

    sd_block_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_buf (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rdata     = buf_sel_q ? ram_rdata : rdata_q;
    assign blk_req   = blk_req_q;
    assign blk_we    = dir_q;
    assign blk_addr  = {sector_q, cnt_q};
    assign blk_wdata = dir_q ? ram_rdata : '0;
`ifdef SD_BLOCK_DEV_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_sd_block_dev.sv
// tb/tb_sd_block_dev.sv - scoreboard bench for sd_block_dev (default build or SD_BLOCK_DEV_IRQ_EN)
module tb_sd_block_dev;

    localparam int          DATA_W   = 64;
    localparam int          ADDR_W   = 7;
    localparam int          SECTOR_W = 32;
    localparam int          DEPTH    = 64;
    localparam int          PTR_W    = 6;
    localparam int unsigned CAPACITY = 32'd1 << 20;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic                      cen = 1'b0;
    logic                      wen = 1'b0;
    logic [ADDR_W-1:0]         addr = '0;
    logic [DATA_W-1:0]         wdata = '0;
    logic [DATA_W-1:0]         rdata;
    logic                      blk_req;
    logic                      blk_we;
    logic [SECTOR_W+PTR_W-1:0] blk_addr;
    logic [DATA_W-1:0]         blk_wdata;
    logic                      blk_ack = 1'b0;
    logic [DATA_W-1:0]         blk_rdata = '0;
`ifdef SD_BLOCK_DEV_IRQ_EN
    logic                      irq;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];
    logic [63:0] model_buf [DEPTH];
    logic [63:0] got;

    always #5 clock = ~clock;

    sd_block_dev dut (
        .clock     (clock),
        .reset     (reset),
        .cen       (cen),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .blk_req   (blk_req),
        .blk_we    (blk_we),
        .blk_addr  (blk_addr),
        .blk_wdata (blk_wdata),
        .blk_ack   (blk_ack),
        .blk_rdata (blk_rdata)
`ifdef SD_BLOCK_DEV_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic mmio_write(input int a, input logic [63:0] d);
        @(negedge clock);
        wen = 1'b1; addr = 7'(a); wdata = d;
        @(negedge clock);
        wen = 1'b0;
    endtask

    task automatic mmio_read(input int a, output logic [63:0] d);
        @(negedge clock);
        cen = 1'b1; addr = 7'(a);
        @(negedge clock);
        cen = 1'b0;
        d = rdata;
    endtask

    task automatic mmio_rw(input int a, input logic [63:0] dw, output logic [63:0] d);
        @(negedge clock);
        cen = 1'b1; wen = 1'b1; addr = 7'(a); wdata = dw;
        @(negedge clock);
        cen = 1'b0; wen = 1'b0;
        d = rdata;
    endtask

    // Backing-store responder: acks every stride-th cycle of blk_req
    task automatic serve(input int stride, input int n_words, input logic [31:0] sector, input logic is_wr);
        int acked = 0;
        int cyc = 0;
        while (acked < n_words && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            blk_ack = 1'b0;
            if (blk_req) begin
                chk("blk_we", 64'(blk_we), 64'(is_wr));
                if (is_wr) chk("blk_wdata", blk_wdata, model_buf[acked]);
                if (cyc % stride == 0) begin
                    chk("blk_addr", 64'(blk_addr), 64'({sector, acked[5:0]}));
                    if (!is_wr) begin
                        blk_rdata = 64'hA5A5_0000 + 64'(acked);
                        sb_q.push_back(blk_rdata);
                        model_buf[acked] = blk_rdata;
                    end
                    blk_ack = 1'b1;
                    acked++;
                end
            end
        end
        chk("acked_words", 64'(acked), 64'(n_words));
        @(negedge clock);
        blk_ack = 1'b0;
    endtask

    task automatic readback(input int n);
        logic [63:0] d;
        mmio_write(3, 64'd0);
        for (int i = 0; i < n; i++) begin
            mmio_read(4, d);
            if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
            else chk("bufdata", d, sb_q.pop_front());
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_blk_req", 64'(blk_req), 64'd0);
        chk("rst_blk_we", 64'(blk_we), 64'd0);
        chk("rst_blk_addr", 64'(blk_addr), 64'd0);
        chk("rst_blk_wdata", blk_wdata, 64'd0);
`ifdef SD_BLOCK_DEV_IRQ_EN
        chk("rst_irq", 64'(irq), 64'd0);
`endif
        reset = 1'b1;
        mmio_read(2, got); chk("status_rst", got, 64'd0);
        mmio_read(5, got); chk("cap", got, 64'(CAPACITY));
        mmio_read(7, got); chk("unmapped", got, 64'd0);
        mmio_write(7, 64'hDEAD);
        mmio_read(7, got); chk("unmapped_wr", got, 64'd0);
        mmio_write(6, 64'd3);
        mmio_read(6, got);
`ifdef SD_BLOCK_DEV_IRQ_EN
        chk("ie_reg", got, 64'd3);
`else
        chk("ie_absent", got, 64'd0);
`endif
        // Simultaneous read and write returns the old value
        mmio_rw(1, 64'd7, got); chk("rw_old", got, 64'd0);
        mmio_read(1, got); chk("rw_new", got, 64'd7);

        // Buffer fill and readback with pointer wrap
        mmio_write(3, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            mmio_write(4, 64'h1111_0000 + 64'(i));
            sb_q.push_back(64'h1111_0000 + 64'(i));
        end
        readback(DEPTH);
        mmio_read(3, got); chk("bufptr_wrap", got, 64'd0);

        // Read transfer, ack every cycle
        mmio_write(1, 64'd5);
        mmio_write(0, 64'd1);
        serve(1, DEPTH, 32'd5, 1'b0);
        mmio_read(2, got); chk("status_rd_done", got, 64'b010);
        chk("req_low_rd", 64'(blk_req), 64'd0);
        readback(DEPTH);

        // Write transfer with stalls
        mmio_write(0, 64'd2);
        serve(3, DEPTH, 32'd5, 1'b1);
        repeat (5) @(negedge clock);
        chk("req_low_wr", 64'(blk_req), 64'd0);
        mmio_read(2, got); chk("status_wr_done", got, 64'b010);

        // Range error and write-1-to-clear
`ifdef SD_BLOCK_DEV_IRQ_EN
        mmio_write(6, 64'd2);
`endif
        mmio_write(2, 64'b010);
        mmio_write(1, 64'(CAPACITY));
        mmio_write(0, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("range_no_req", 64'(blk_req), 64'd0);
        end
        mmio_read(2, got); chk("status_range", got, 64'b100);
`ifdef SD_BLOCK_DEV_IRQ_EN
        chk("irq_err", 64'(irq), 64'd1);
`endif
        mmio_write(2, 64'b100);
        mmio_read(2, got); chk("status_w1c", got, 64'd0);
`ifdef SD_BLOCK_DEV_IRQ_EN
        chk("irq_clr", 64'(irq), 64'd0);
`endif

        // Busy guard during a read transfer
        mmio_write(1, 64'd5);
        mmio_write(0, 64'd1);
        fork
            serve(2, DEPTH, 32'd5, 1'b0);
            begin
                logic [63:0] g;
                repeat (3) @(negedge clock);
                mmio_read(2, g); chk("guard_busy", g, 64'b001);
                mmio_write(0, 64'd2);
                mmio_write(1, 64'd9);
                mmio_read(4, g); chk("guard_bufdata", g, 64'd0);
                mmio_read(2, g); chk("guard_err", g, 64'b101);
            end
        join
        mmio_read(2, got); chk("guard_done", got, 64'b110);
        mmio_read(1, got); chk("guard_sector", got, 64'd5);
        mmio_read(3, got); chk("guard_bufptr", got, 64'd0);
        readback(DEPTH);

        // Reset in the middle of a transfer
        mmio_write(0, 64'd1);
        mmio_read(5, got);
        serve(1, 20, 32'd5, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_req", 64'(blk_req), 64'd0);
        chk("midrst_rdata", rdata, 64'd0);
`ifdef SD_BLOCK_DEV_IRQ_EN
        chk("midrst_irq", 64'(irq), 64'd0);
`endif
        reset = 1'b1;
        sb_q.delete();
        mmio_read(2, got); chk("midrst_status", got, 64'd0);
        mmio_read(1, got); chk("midrst_sector", got, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
